fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling FIFO between instruction fetch and decode.
- Accepts (pc, instruction) pairs returned by the icache and presents them in order to the ID stage with a valid/ready handshake.
- Absorbs decode stalls so fetch keeps requesting, and discards wrong-path instructions on branch redirect.
- A 1-bit fetch epoch, toggled on every flush, lets stale icache responses still in flight be dropped on arrival.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately
enq_valid  input  1  icache response valid this cycle
enq_pc  input  32  pc of the returned instruction
enq_instr  input  32  returned instruction word
enq_epoch  input  1  epoch tag the request was issued under
enq_ready  output  1  queue can accept an entry this cycle
cur_epoch  output  1  current epoch; fetch tags new requests with it
flush  input  1  branch taken or redirect; discard all queued and in-flight instructions
deq_valid  output  1  head entry valid for decode
deq_pc  output  32  head entry pc
deq_instr  output  32  head entry instruction
deq_ready  input  1  decode consumes the head this cycle; low when ID is stalled
count  output  CNT_W  number of valid entries

Behaviour:
- Reset (rst=0, asynchronous):
  - head/tail pointers = 0, count = 0, cur_epoch = 0.
  - deq_valid = 0, enq_ready = 1.
  - Storage cleared to 0, so deq_pc = deq_instr = 0.
- Storage: circular buffer of DEPTH entries, each {pc[31:0], instr[31:0]}.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Full/empty are derived from count.
- enq_ready = (count != DEPTH).
  - Registered-state only; no combinational dependence on deq_ready.
  - A full queue refuses enqueue even when a dequeue occurs in the same cycle.
- Enqueue fires when enq_valid & enq_ready & ~flush & (enq_epoch == cur_epoch).
  - Entry written at tail; tail advances by 1.
- Stale drop: enq_valid with enq_epoch != cur_epoch is silently discarded.
  - No state change; does not depend on enq_ready.
- Dequeue fires when deq_valid & deq_ready & ~flush; head advances by 1.
- Outputs:
  - deq_valid = (count != 0).
  - deq_pc/deq_instr are the head entry, driven combinationally from storage.
  - Contents are don't-care when deq_valid = 0.
- Latency:
  - An entry enqueued in cycle N is visible at deq in cycle N+1 at the earliest.
  - No same-cycle enqueue-to-dequeue bypass.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Count update: count_next = count + enq_fire - deq_fire; never exceeds DEPTH, never underflows.
- Flush (highest priority, synchronous):
  - Next edge: head = tail = 0, count = 0, cur_epoch toggles.
  - Any enqueue or dequeue presented in the flush cycle is ignored.
  - Storage is not cleared.
  - Responses arriving afterwards with the old epoch are dropped by the stale rule.
- Back-to-back flushes: each toggles cur_epoch.
  - Fetch must not issue more than one epoch of outstanding requests; an epoch aliasing after two flushes is outside this block's contract.
- Empty with deq_ready=1: no action, and deq_valid stays 0.
- Full with enq_valid=1 and a matching epoch: entry not accepted.
  - The producer holds enq_* until enq_ready is seen.
- Reset mid-operation: asynchronous clear regardless of flush or enqueue activity; first valid operation on the first edge after rst returns to 1.

Test Plan:
- Basic fill: enqueue pcs 0x60, 0x64, 0x68, 0x6C (instr 0x13, epoch 0) with deq_ready=0 -> count = 4, enq_ready = 0, deq_pc = 0x60; a 5th enqueue (0x70) is dropped.
- Drain in order: from the full state, deq_ready=1 for 4 cycles -> deq_pc sequence 0x60, 0x64, 0x68, 0x6C; count 3, 2, 1, 0; deq_valid = 0 after the last.
- Simultaneous enqueue/dequeue at count = 2 for 6 cycles -> count stays 2; pointers wrap past 3 to 0; order preserved.
- Flush: with 3 entries queued, assert flush while presenting an enqueue of 0x80 -> next cycle count = 0, deq_valid = 0, cur_epoch = 1; 0x80 not stored.
- Stale drop: after the flush, enqueue pc 0x90 with epoch 0 -> dropped, count = 0; then 0x200 with epoch 1 -> accepted, deq_pc = 0x200 next cycle.
- Asynchronous reset: drop rst low mid-cycle with 2 entries queued -> count = 0, deq_valid = 0, cur_epoch = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: icache response side, flush/epoch, and decode side.
// Both enq and deq use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic              enq_valid;
  logic [31:0]       enq_pc;
  logic [31:0]       enq_instr;
  logic              enq_epoch;
  logic              enq_ready;
  logic              cur_epoch;
  logic              flush;
  logic              deq_valid;
  logic [31:0]       deq_pc;
  logic [31:0]       deq_instr;
  logic              deq_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output enq_valid, enq_pc, enq_instr, enq_epoch, flush, deq_ready,
    input  enq_ready, cur_epoch, deq_valid, deq_pc, deq_instr, count
  );

  modport slave (
    input  enq_valid, enq_pc, enq_instr, enq_epoch, flush, deq_ready,
    output enq_ready, cur_epoch, deq_valid, deq_pc, deq_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular-buffer FIFO between fetch and decode, with flush and a 1-bit epoch
// that drops icache responses issued before the most recent redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             epoch_q;
  logic             full;
  logic             empty;
  logic             enq_fire;
  logic             deq_fire;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Stale responses fail the epoch match and fall out here with no side effect.
  assign enq_fire = bus.enq_valid & ~full & ~bus.flush & (bus.enq_epoch == epoch_q);
  assign deq_fire = ~empty & bus.deq_ready & ~bus.flush;

  assign bus.enq_ready = ~full;
  assign bus.deq_valid = ~empty;
  assign bus.deq_pc    = pc_mem[head_q];
  assign bus.deq_instr = instr_mem[head_q];
  assign bus.count     = count_q;
  assign bus.cur_epoch = epoch_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      epoch_q <= 1'b0;
    end else if (bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      epoch_q <= ~epoch_q;
    end else begin
      if (enq_fire) tail_q <= tail_q + PTR_W'(1);
      if (deq_fire) head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  // Storage is only cleared by reset; a flush leaves stale words behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (enq_fire) begin
      pc_mem[tail_q]    <= bus.enq_pc;
      instr_mem[tail_q] <= bus.enq_instr;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [63:0] exp_q[$];
  logic        m_epoch;

  fetch_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ep, input logic fl, input logic dr);
    bus.enq_valid = v;
    bus.enq_pc    = pc;
    bus.enq_instr = ins;
    bus.enq_epoch = ep;
    bus.flush     = fl;
    bus.deq_ready = dr;
  endtask

  task automatic check_state(input string tag);
    logic [63:0] head;
    check({tag, "_count"}, 64'(bus.count), 64'(exp_q.size()));
    check({tag, "_deq_valid"}, 64'(bus.deq_valid), 64'(exp_q.size() != 0));
    check({tag, "_enq_ready"}, 64'(bus.enq_ready), 64'(exp_q.size() != DEPTH));
    check({tag, "_epoch"}, 64'(bus.cur_epoch), 64'(m_epoch));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check({tag, "_deq_pc"}, 64'(bus.deq_pc), 64'(head[63:32]));
      check({tag, "_deq_instr"}, 64'(bus.deq_instr), 64'(head[31:0]));
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    logic ef, df;
    logic [63:0] ent;
    ef  = bus.enq_valid && (exp_q.size() < DEPTH) && !bus.flush && (bus.enq_epoch == m_epoch);
    df  = (exp_q.size() > 0) && bus.deq_ready && !bus.flush;
    ent = {bus.enq_pc, bus.enq_instr};
    @(posedge clk);
    if (bus.flush) begin
      exp_q.delete();
      m_epoch = ~m_epoch;
    end else begin
      if (df) void'(exp_q.pop_front());
      if (ef) exp_q.push_back(ent);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_epoch  = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    check("reset_deq_pc", 64'(bus.deq_pc), 64'h0);
    check("reset_deq_instr", 64'(bus.deq_instr), 64'h0);
    rst = 1'b1;

    // Basic fill, then a 5th enqueue refused while full.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h60 + 32'(4 * i), 32'h13, 1'b0, 1'b0, 1'b0);
      cycle("fill");
    end
    check("fill_full_count", 64'(bus.count), 64'd4);
    check("fill_head_pc", 64'(bus.deq_pc), 64'h60);
    drive(1'b1, 32'h70, 32'h13, 1'b0, 1'b0, 1'b0);
    cycle("fill_over");

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(bus.deq_pc), 64'h60 + 64'(4 * i));
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cycle("drain");
      check("drain_count", 64'(bus.count), 64'(3 - i));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle("drain_empty");

    // Bring to count 2, then simultaneous enq/deq with pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
      cycle("pre_sim");
    end
    for (int i = 2; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b1);
      cycle("sim");
      check("sim_count", 64'(bus.count), 64'd2);
    end

    // Top up to 3 entries, then flush with a concurrent enqueue.
    drive(1'b1, 32'h120, 32'h2000, 1'b0, 1'b0, 1'b0);
    cycle("pre_flush");
    drive(1'b1, 32'h80, 32'h13, 1'b0, 1'b1, 1'b1);
    cycle("flush");
    check("flush_epoch", 64'(bus.cur_epoch), 64'd1);

    // Stale drop, then matching epoch accepted.
    drive(1'b1, 32'h90, 32'h13, 1'b0, 1'b0, 1'b0);
    cycle("stale");
    drive(1'b1, 32'h200, 32'h33, 1'b1, 1'b0, 1'b0);
    cycle("fresh");
    check("fresh_pc", 64'(bus.deq_pc), 64'h200);

    // Asynchronous reset mid-cycle with 2 entries queued.
    drive(1'b1, 32'h204, 32'h34, 1'b1, 1'b0, 1'b0);
    cycle("pre_arst");
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    m_epoch = 1'b0;
    check_state("arst");
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic ep;
      ep = ($urandom_range(0, 7) == 0) ? ~m_epoch : m_epoch;
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, ep,
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
